// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and the rotating-priority search for the round-robin arbiter.
package decoder_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;

  // Returns {found, id}: the first set request at or after ptr, wrapping mod NUM_REQ.
  function automatic logic [ID_W:0] next_rr(input logic [NUM_REQ-1:0] req,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] idx;
    next_rr = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + ID_W'(k);
      if (req[idx]) next_rr = {1'b1, idx};
    end
  endfunction

endpackage

// File: rtl/decoder_rr_arbiter_decoder_3_8.sv
// Enabled 3-to-8 one-hot decoder used as the arbiter's grant encoder.
module decoder_3_8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] out
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_dec
    assign out[gi] = en && (sel == 3'(gi));
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Eight-way round-robin arbiter with grant holding, release detection and hold-time limit.
module decoder_rr_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               timeout,
  output logic [CNT_W-1:0]   hold_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t      state;
  logic [ID_W-1:0] ptr;
  logic [ID_W:0]   pick;

  assign pick = next_rr(req, ptr);

  // Grant is a pure decode of registered state, so it adds no latency.
  decoder_3_8 u_grant_enc (
    .en  (busy),
    .sel (gnt_id),
    .out (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick[ID_W]) begin
            gnt_id   <= pick[ID_W-1:0];
            busy     <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + CNT_W'(1);
          // A voluntary release wins over an expiry in the same cycle.
          if (!req[gnt_id]) begin
            busy  <= 1'b0;
            state <= RELEASE;
          end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
            busy    <= 1'b0;
            timeout <= 1'b1;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          // The departing owner becomes lowest priority for the next scan.
          ptr      <= gnt_id + ID_W'(1);
          hold_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
